// File: rtl/draw_engine_arbiter_if.sv
// Bundle of handshake signals between the draw-engine arbiter, its
// requesters (hook, gold/rock, HUD, background restore) and the draw engine.
// master: the arbiter side. slave: the requester/engine side.
interface draw_engine_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // Requester side
    logic [NUM_REQ-1:0]   req;
    logic [9*NUM_REQ-1:0] req_x;
    logic [8*NUM_REQ-1:0] req_y;
    logic [NUM_REQ-1:0]   req_erase;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;

    // Draw engine side
    logic                 draw_object_done;
    logic                 start_draw;
    logic [8:0]           draw_x_start;
    logic [7:0]           draw_y_start;
    logic                 draw_erase;

    // Status
    logic                 busy;
    logic                 timeout_err;

    modport master (
        input  req, req_x, req_y, req_erase, draw_object_done,
        output start_draw, draw_x_start, draw_y_start, draw_erase,
        output grant, done, busy, timeout_err
    );

    modport slave (
        output req, req_x, req_y, req_erase, draw_object_done,
        input  start_draw, draw_x_start, draw_y_start, draw_erase,
        input  grant, done, busy, timeout_err
    );
endinterface

// File: rtl/draw_engine_arbiter.sv
// Round-robin arbiter sharing the single object-draw engine between
// NUM_REQ requesters. A winner's start coordinate and erase flag are
// latched once, the engine is started, and a one-cycle done pulse is
// returned to the winner when the engine reports completion.
//
// Optional feature: define DRAW_TIMEOUT_EN to add a DRAW-state watchdog
// (TIMEOUT_CYCLES) that forces a release and sets a sticky timeout_err.
// Without the macro the engine is waited on indefinitely and timeout_err
// is tied low.
module draw_engine_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter int          IDX_W          = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000
) (
    input  logic                  clk,
    input  logic                  resetn,
    draw_engine_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LATCH   = 2'd1,
        S_DRAW    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    state_t               state_r;
    logic [IDX_W-1:0]     last_idx_r;
    logic [IDX_W-1:0]     win_idx_r;
    logic [8:0]           lat_x_r;
    logic [7:0]           lat_y_r;
    logic                 lat_erase_r;
    logic                 first_draw_r;

    logic                 start_draw_r;
    logic [8:0]           draw_x_r;
    logic [7:0]           draw_y_r;
    logic                 draw_erase_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [NUM_REQ-1:0]   done_r;
    logic                 busy_r;

    logic [8:0]           x_arr_s [NUM_REQ];
    logic [7:0]           y_arr_s [NUM_REQ];
    logic                 found_s;
    logic [IDX_W-1:0]     pick_s;
    logic                 accept_s;
    logic                 tmo_hit_s;

    // Unpack the per-requester coordinate buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            x_arr_s[i] = bus.req_x[9*i +: 9];
            y_arr_s[i] = bus.req_y[8*i +: 8];
        end
    end

    // Round-robin pick: first active request after last_idx, modulo NUM_REQ.
    always_comb begin
        found_s = 1'b0;
        pick_s  = last_idx_r;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [IDX_W-1:0] cand_v;
            cand_v = IDX_W'((int'(last_idx_r) + k) % NUM_REQ);
            if (!found_s && bus.req[cand_v]) begin
                found_s = 1'b1;
                pick_s  = cand_v;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Engine completion is honoured only from the second DRAW cycle on,
    // so a done left over from a previous object cannot end this one early.
    always_comb begin
        if (state_r == S_DRAW && !first_draw_r && bus.draw_object_done) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

`ifdef DRAW_TIMEOUT_EN
    logic [15:0] tmo_cnt_r;
    logic        timeout_err_r;

    // Watchdog fires in the DRAW cycle whose count reaches TIMEOUT_CYCLES-1.
    always_comb begin
        if (state_r == S_DRAW && tmo_cnt_r == (TIMEOUT_CYCLES - 16'd1)) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // DRAW cycle counter and sticky timeout flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_r     <= 16'd0;
            timeout_err_r <= 1'b0;
        end else begin
            case (state_r)
                S_LATCH: tmo_cnt_r <= 16'd0;
                S_DRAW:  tmo_cnt_r <= tmo_cnt_r + 16'd1;
                default: tmo_cnt_r <= tmo_cnt_r;
            endcase
            if (tmo_hit_s && !accept_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    assign bus.timeout_err = timeout_err_r;
`else
    logic unused_tmo_s;

    // No watchdog in this build: DRAW waits for the engine indefinitely.
    always_comb begin
        tmo_hit_s = 1'b0;
    end

    assign unused_tmo_s    = ^TIMEOUT_CYCLES;
    assign bus.timeout_err = 1'b0;
`endif

    // Arbiter FSM with registered engine and requester outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= S_IDLE;
            last_idx_r   <= IDX_W'(NUM_REQ - 1);
            win_idx_r    <= '0;
            lat_x_r      <= 9'd0;
            lat_y_r      <= 8'd0;
            lat_erase_r  <= 1'b0;
            first_draw_r <= 1'b0;
            start_draw_r <= 1'b0;
            draw_x_r     <= 9'd0;
            draw_y_r     <= 8'd0;
            draw_erase_r <= 1'b0;
            grant_r      <= '0;
            done_r       <= '0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= '0;
                    if (found_s) begin
                        lat_x_r     <= x_arr_s[pick_s];
                        lat_y_r     <= y_arr_s[pick_s];
                        lat_erase_r <= bus.req_erase[pick_s];
                        win_idx_r   <= pick_s;
                        grant_r     <= onehot(pick_s);
                        busy_r      <= 1'b1;
                        state_r     <= S_LATCH;
                    end else begin
                        grant_r     <= '0;
                        busy_r      <= 1'b0;
                        state_r     <= S_IDLE;
                    end
                end
                S_LATCH: begin
                    start_draw_r <= 1'b1;
                    draw_x_r     <= lat_x_r;
                    draw_y_r     <= lat_y_r;
                    draw_erase_r <= lat_erase_r;
                    first_draw_r <= 1'b1;
                    state_r      <= S_DRAW;
                end
                S_DRAW: begin
                    first_draw_r <= 1'b0;
                    if (accept_s || tmo_hit_s) begin
                        start_draw_r <= 1'b0;
                        draw_x_r     <= 9'd0;
                        draw_y_r     <= 8'd0;
                        draw_erase_r <= 1'b0;
                        done_r       <= onehot(win_idx_r);
                        state_r      <= S_RELEASE;
                    end else begin
                        state_r      <= S_DRAW;
                    end
                end
                S_RELEASE: begin
                    done_r     <= '0;
                    grant_r    <= '0;
                    busy_r     <= 1'b0;
                    last_idx_r <= win_idx_r;
                    state_r    <= S_IDLE;
                end
                default: begin
                    start_draw_r <= 1'b0;
                    draw_x_r     <= 9'd0;
                    draw_y_r     <= 8'd0;
                    draw_erase_r <= 1'b0;
                    grant_r      <= '0;
                    done_r       <= '0;
                    busy_r       <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.start_draw   = start_draw_r;
    assign bus.draw_x_start = draw_x_r;
    assign bus.draw_y_start = draw_y_r;
    assign bus.draw_erase   = draw_erase_r;
    assign bus.grant        = grant_r;
    assign bus.done         = done_r;
    assign bus.busy         = busy_r;

endmodule

// File: tb/tb_draw_engine_arbiter.sv
// Directed, table-driven bench for draw_engine_arbiter. When built with
// DRAW_TIMEOUT_EN the watchdog sequence runs with TIMEOUT_CYCLES = 16.
module tb_draw_engine_arbiter;

`ifdef DRAW_TIMEOUT_EN
    localparam logic [15:0] TMO = 16'd16;
`else
    localparam logic [15:0] TMO = 16'd20000;
`endif

    logic clk;
    logic resetn;

    draw_engine_arbiter_if #(.NUM_REQ(4)) bus ();

    draw_engine_arbiter #(
        .NUM_REQ        (4),
        .IDX_W          (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       dod;
        logic       exp_start;
        logic [8:0] exp_x;
        logic [7:0] exp_y;
        logic       exp_erase;
        logic [3:0] exp_grant;
        logic [3:0] exp_done;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic check_all(input string tag, input logic st, input logic [8:0] x,
                             input logic [7:0] y, input logic e, input logic [3:0] g,
                             input logic [3:0] d, input logic b, input logic terr);
        check({tag, " start_draw"},   32'(bus.start_draw),   32'(st));
        check({tag, " draw_x_start"}, 32'(bus.draw_x_start), 32'(x));
        check({tag, " draw_y_start"}, 32'(bus.draw_y_start), 32'(y));
        check({tag, " draw_erase"},   32'(bus.draw_erase),   32'(e));
        check({tag, " grant"},        32'(bus.grant),        32'(g));
        check({tag, " done"},         32'(bus.done),         32'(d));
        check({tag, " busy"},         32'(bus.busy),         32'(b));
        check({tag, " timeout_err"},  32'(bus.timeout_err),  32'(terr));
    endtask

    task automatic add_vec(input logic rst, input logic [3:0] req, input logic dod,
                           input logic st, input logic [8:0] x, input logic [7:0] y,
                           input logic e, input logic [3:0] g, input logic [3:0] d,
                           input logic b);
        vec_t v;
        v.rst = rst; v.req = req; v.dod = dod; v.exp_start = st;
        v.exp_x = x; v.exp_y = y; v.exp_erase = e; v.exp_grant = g;
        v.exp_done = d; v.exp_busy = b;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        bus.req = 4'b0000;
        bus.draw_object_done = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fixed per-requester coordinates and erase flags.
    logic [8:0] rx [4];
    logic [7:0] ry [4];
    logic [3:0] re;

    task automatic set_coords();
        for (int i = 0; i < 4; i++) begin
            bus.req_x[9*i +: 9] = rx[i];
            bus.req_y[8*i +: 8] = ry[i];
        end
        bus.req_erase = re;
    endtask

    initial begin
        int order [5];

        rx[0] = 9'd146; ry[0] = 8'd40;
        rx[1] = 9'd10;  ry[1] = 8'd20;
        rx[2] = 9'd300; ry[2] = 8'd200;
        rx[3] = 9'd511; ry[3] = 8'd239;
        re    = 4'b0100;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

        resetn = 1'b1;
        bus.req = 4'b0000;
        bus.draw_object_done = 1'b0;
        set_coords();
        #3;
        do_reset();
        check_all("reset", 1'b0, 9'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Idle with no requests for 10 cycles.
        for (int i = 0; i < 10; i++)
            add_vec(1'b0, 4'b0000, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b0);

        // Single request from requester 0, dropped mid-draw, engine done 5 cycles after start.
        add_vec(1'b0, 4'b0001, 1'b0, 1'b0, 9'd0,   8'd0,  1'b0, 4'b0001, 4'b0000, 1'b1);
        add_vec(1'b0, 4'b0001, 1'b0, 1'b1, 9'd146, 8'd40, 1'b0, 4'b0001, 4'b0000, 1'b1);
        add_vec(1'b0, 4'b0001, 1'b0, 1'b1, 9'd146, 8'd40, 1'b0, 4'b0001, 4'b0000, 1'b1);
        add_vec(1'b0, 4'b0000, 1'b0, 1'b1, 9'd146, 8'd40, 1'b0, 4'b0001, 4'b0000, 1'b1);
        add_vec(1'b0, 4'b0000, 1'b0, 1'b1, 9'd146, 8'd40, 1'b0, 4'b0001, 4'b0000, 1'b1);
        add_vec(1'b0, 4'b0000, 1'b0, 1'b1, 9'd146, 8'd40, 1'b0, 4'b0001, 4'b0000, 1'b1);
        add_vec(1'b0, 4'b0000, 1'b1, 1'b0, 9'd0,   8'd0,  1'b0, 4'b0001, 4'b0001, 1'b1);
        add_vec(1'b0, 4'b0000, 1'b0, 1'b0, 9'd0,   8'd0,  1'b0, 4'b0000, 4'b0000, 1'b0);
        add_vec(1'b0, 4'b0000, 1'b0, 1'b0, 9'd0,   8'd0,  1'b0, 4'b0000, 4'b0000, 1'b0);

        // All four requesting continuously after a reset: served 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            int         w;
            logic [3:0] g;
            w = order[k];
            g = 4'b0001 << w;
            add_vec(k == 0, 4'b1111, 1'b0, 1'b0, 9'd0,  8'd0,  1'b0,  g, 4'b0000, 1'b1);
            add_vec(1'b0,   4'b1111, 1'b0, 1'b1, rx[w], ry[w], re[w], g, 4'b0000, 1'b1);
            add_vec(1'b0,   4'b1111, 1'b1, 1'b1, rx[w], ry[w], re[w], g, 4'b0000, 1'b1);
            add_vec(1'b0,   4'b1111, 1'b1, 1'b0, 9'd0,  8'd0,  1'b0,  g, g,       1'b1);
            add_vec(1'b0,   4'b1111, 1'b0, 1'b0, 9'd0,  8'd0,  1'b0,  4'b0000, 4'b0000, 1'b0);
        end

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            bus.req = vecs[i].req;
            bus.draw_object_done = vecs[i].dod;
            step();
            check_all($sformatf("v%0d", i), vecs[i].exp_start, vecs[i].exp_x, vecs[i].exp_y,
                      vecs[i].exp_erase, vecs[i].exp_grant, vecs[i].exp_done,
                      vecs[i].exp_busy, 1'b0);
        end

        // Stale done held through LATCH and first DRAW cycle; req_x changed mid-draw.
        // State is IDLE with last_idx = 0, so requester 0 alone wins.
        bus.req = 4'b0001;
        bus.draw_object_done = 1'b1;
        step();
        check("stale latch grant", 32'(bus.grant), 32'(4'b0001));
        step();
        check("stale draw start", 32'(bus.start_draw), 32'(1'b1));
        bus.req_x[8:0] = 9'd200;
        step();
        check("stale first cycle held", 32'(bus.start_draw), 32'(1'b1));
        check("stale no early done", 32'(bus.done), 32'(4'b0000));
        check("latched x kept", 32'(bus.draw_x_start), 32'(9'd146));
        step();
        check("stale release done", 32'(bus.done), 32'(4'b0001));
        bus.draw_object_done = 1'b0;
        bus.req = 4'b0000;
        step();
        check("stale back idle", 32'(bus.busy), 32'(1'b0));
        set_coords();

        // Reset two cycles into DRAW, then requester 2 served normally.
        bus.req = 4'b0010;
        step();
        step();
        step();
        check("pre-reset drawing", 32'(bus.start_draw), 32'(1'b1));
        resetn = 1'b0;
        #2;
        check("async reset start_draw", 32'(bus.start_draw), 32'(1'b0));
        check("async reset grant", 32'(bus.grant), 32'(4'b0000));
        check("async reset busy", 32'(bus.busy), 32'(1'b0));
        bus.req = 4'b0100;
        step();
        resetn = 1'b1;
        step();
        check("post-reset latch grant", 32'(bus.grant), 32'(4'b0100));
        step();
        check_all("post-reset draw", 1'b1, 9'd300, 8'd200, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0);
        bus.draw_object_done = 1'b1;
        step();
        step();
        check("post-reset done", 32'(bus.done), 32'(4'b0100));
        bus.draw_object_done = 1'b0;
        bus.req = 4'b0000;
        step();
        check("post-reset idle grant", 32'(bus.grant), 32'(4'b0000));

`ifdef DRAW_TIMEOUT_EN
        // Engine never signals done: release after 16 DRAW cycles, sticky error.
        do_reset();
        bus.req = 4'b0001;
        step();
        step();
        check("tmo draw1", 32'(bus.start_draw), 32'(1'b1));
        for (int k = 1; k < 16; k++) begin
            step();
            check($sformatf("tmo draw%0d", k + 1), 32'({bus.start_draw, bus.done}), 32'(5'b10000));
        end
        step();
        check("tmo done pulse", 32'(bus.done), 32'(4'b0001));
        check("tmo err set", 32'(bus.timeout_err), 32'(1'b1));
        check("tmo start low", 32'(bus.start_draw), 32'(1'b0));
        bus.req = 4'b0011;
        step();
        check("tmo idle grant", 32'(bus.grant), 32'(4'b0000));
        step();
        check("tmo next grant", 32'(bus.grant), 32'(4'b0010));
        check("tmo err sticky", 32'(bus.timeout_err), 32'(1'b1));
        bus.req = 4'b0000;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
